// File: rtl/hacd_pkg.sv
// Shared HACD definitions: AXI widths, table geometry, table base
// addresses and the table entry types.
package hacd_pkg;

    localparam int AXI_ADDR_W    = 64;
    localparam int AXI_DATA_W    = 512;
    localparam int AXI_STRB_W    = AXI_DATA_W / 8;

    // Entry ids run 1..MAX; id 0 is reserved as "no entry".
    localparam int ATT_ENTRY_MAX = 1024;
    localparam int LST_ENTRY_MAX = 512;

    localparam logic [AXI_ADDR_W-1:0] HAWK_ATT_START  = 64'h0000_0001_0000_0000;
    localparam logic [AXI_ADDR_W-1:0] HAWK_LIST_START = 64'h0000_0002_0000_0000;

    typedef logic [63:0]  AttEntry;
    typedef logic [127:0] ListEntry;

    // Bits needed to hold the value itself, so the largest id (== MAX) fits.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int ATT_ID_W = clogb2(ATT_ENTRY_MAX);
    localparam int LST_ID_W = clogb2(LST_ENTRY_MAX);

endpackage

// File: rtl/hawk_rd_pkg.sv
// HAWK table helpers shared by the read and write paths: line address
// and slot decode for ATT (8 x 64-bit per line) and list (4 x 128-bit
// per line), entry extraction and the write-side merge/strobe builders.
package hawk_rd_pkg;

    import hacd_pkg::*;

    typedef enum logic {
        TBL_WR_ATT = 1'b0,
        TBL_WR_TOL = 1'b1
    } TBL_WR_TYPE;

    // Arithmetic is done at full address width so the last id never wraps.
    function automatic logic [AXI_ADDR_W-1:0] att_line_addr(input logic [ATT_ID_W-1:0] id);
        logic [AXI_ADDR_W-1:0] idx;
        idx = AXI_ADDR_W'(id) - AXI_ADDR_W'(1);
        return HAWK_ATT_START + ((idx >> 3) << 6);
    endfunction

    function automatic logic [AXI_ADDR_W-1:0] lst_line_addr(input logic [LST_ID_W-1:0] id);
        logic [AXI_ADDR_W-1:0] idx;
        idx = AXI_ADDR_W'(id) - AXI_ADDR_W'(1);
        return HAWK_LIST_START + ((idx >> 2) << 6);
    endfunction

    function automatic logic [2:0] att_slot(input logic [ATT_ID_W-1:0] id);
        return 3'(id - ATT_ID_W'(1));
    endfunction

    // id[1:0] 01->0, 10->1, 11->2, 00->3, i.e. (id-1) modulo 4.
    function automatic logic [1:0] lst_slot(input logic [LST_ID_W-1:0] id);
        return 2'(id - LST_ID_W'(1));
    endfunction

    function automatic AttEntry att_get(input logic [AXI_DATA_W-1:0] line,
                                        input logic [2:0] slot);
        return line[{slot, 6'd0} +: 64];
    endfunction

    function automatic ListEntry lst_get(input logic [AXI_DATA_W-1:0] line,
                                         input logic [1:0] slot);
        return line[{slot, 7'd0} +: 128];
    endfunction

    function automatic logic [AXI_DATA_W-1:0] att_merge(input logic [AXI_DATA_W-1:0] line,
                                                        input AttEntry entry,
                                                        input logic [2:0] slot);
        logic [AXI_DATA_W-1:0] d;
        d = line;
        d[{slot, 6'd0} +: 64] = entry;
        return d;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] lst_merge(input logic [AXI_DATA_W-1:0] line,
                                                        input ListEntry entry,
                                                        input logic [1:0] slot);
        logic [AXI_DATA_W-1:0] d;
        d = line;
        d[{slot, 7'd0} +: 128] = entry;
        return d;
    endfunction

    function automatic logic [AXI_STRB_W-1:0] att_strb(input logic [2:0] slot);
        return AXI_STRB_W'(64'hFF) << {slot, 3'd0};
    endfunction

    function automatic logic [AXI_STRB_W-1:0] lst_strb(input logic [1:0] slot);
        return AXI_STRB_W'(64'hFFFF) << {slot, 4'd0};
    endfunction

endpackage

// File: rtl/hawk_tbl_wr_mngr.sv
// HAWK table write manager: turns one ATT or list entry update into a
// single-beat 64-byte AXI write and reports completion with done_o/err_o.
// Build option HAWK_WR_BYTE_STROBE_EN: write only the target entry bytes
// via wstrb instead of read-modify-writing the whole line from line_i.
//
// state  | meaning
// IDLE   | ready for a request (req_ready_o = 1)
// SEND   | AW and W beats outstanding, each dropped once accepted
// WAIT_B | both beats accepted, waiting for the write response
// DONE   | one-cycle done_o pulse, err_o valid, back to IDLE

`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

module hawk_tbl_wr_mngr
    import hacd_pkg::*;
    import hawk_rd_pkg::*;
#(
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  TBL_WR_TYPE                       req_type_i,
    input  logic [ATT_ID_W-1:0]              att_entry_id_i,
    input  AttEntry                          att_entry_i,
    input  logic [LST_ID_W-1:0]              lst_entry_id_i,
    input  ListEntry                         lst_entry_i,
    input  logic [`HACD_AXI4_DATA_WIDTH-1:0] line_i,
    output logic                             awvalid_o,
    output logic [`HACD_AXI4_ADDR_WIDTH-1:0] awaddr_o,
    output logic [3:0]                       awid_o,
    output logic [7:0]                       awlen_o,
    output logic [2:0]                       awsize_o,
    output logic [1:0]                       awburst_o,
    input  logic                             awready_i,
    output logic                             wvalid_o,
    output logic [511:0]                     wdata_o,
    output logic [63:0]                      wstrb_o,
    output logic                             wlast_o,
    input  logic                             wready_i,
    input  logic                             bvalid_i,
    input  logic [1:0]                       bresp_i,
    output logic                             bready_o,
    output logic                             done_o,
    output logic                             err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  aw_pend_q;
    logic                  w_pend_q;
    logic                  err_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] data_q;
    logic [AXI_STRB_W-1:0] strb_q;

    logic                  accept;
    logic                  id_zero;
    logic [2:0]            att_sl;
    logic [1:0]            lst_sl;
    logic [AXI_ADDR_W-1:0] nxt_addr;
    logic [AXI_DATA_W-1:0] nxt_data;
    logic [AXI_STRB_W-1:0] nxt_strb;
    logic                  aw_hs;
    logic                  w_hs;

    assign att_sl = att_slot(att_entry_id_i);
    assign lst_sl = lst_slot(lst_entry_id_i);

`ifdef HAWK_WR_BYTE_STROBE_EN
    logic unused_line;
    assign unused_line = ^line_i;
`endif

    // Decode the incoming request into line address, write data and strobes.
    always_comb begin
        id_zero  = 1'b0;
        nxt_addr = '0;
        nxt_data = '0;
        nxt_strb = '0;
        if (req_type_i == TBL_WR_ATT) begin
            id_zero  = (att_entry_id_i == '0);
            nxt_addr = att_line_addr(att_entry_id_i);
`ifdef HAWK_WR_BYTE_STROBE_EN
            nxt_data = att_merge('0, att_entry_i, att_sl);
            nxt_strb = att_strb(att_sl);
`else
            nxt_data = att_merge(line_i, att_entry_i, att_sl);
            nxt_strb = '1;
`endif
        end else begin
            id_zero  = (lst_entry_id_i == '0);
            nxt_addr = lst_line_addr(lst_entry_id_i);
`ifdef HAWK_WR_BYTE_STROBE_EN
            nxt_data = lst_merge('0, lst_entry_i, lst_sl);
            nxt_strb = lst_strb(lst_sl);
`else
            nxt_data = lst_merge(line_i, lst_entry_i, lst_sl);
            nxt_strb = '1;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = id_zero ? DONE : SEND;
                end
            end
            SEND: begin
                awvalid_o = aw_pend_q;
                wvalid_o  = w_pend_q;
                if ((!aw_pend_q || awready_i) && (!w_pend_q || wready_i)) begin
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && req_valid_i;
    assign aw_hs  = awvalid_o && awready_i;
    assign w_hs   = wvalid_o && wready_i;

    // Capture the payload on accept; track which beats are still pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            if (accept) begin
                err_q <= id_zero;
                if (!id_zero) begin
                    aw_pend_q <= 1'b1;
                    w_pend_q  <= 1'b1;
                    addr_q    <= nxt_addr;
                    data_q    <= nxt_data;
                    strb_q    <= nxt_strb;
                end
            end else begin
                if (aw_hs) begin
                    aw_pend_q <= 1'b0;
                end
                if (w_hs) begin
                    w_pend_q <= 1'b0;
                end
                if ((state_q == WAIT_B) && bvalid_i) begin
                    err_q <= (bresp_i != 2'b00);
                end
            end
        end
    end

    assign awaddr_o  = addr_q;
    assign awid_o    = WR_ID;
    assign awlen_o   = 8'd0;
    assign awsize_o  = 3'b110;
    assign awburst_o = 2'b01;
    assign wdata_o   = data_q;
    assign wstrb_o   = strb_q;
    assign wlast_o   = 1'b1;

endmodule
